// File: rtl/ins_pkg.sv
// Shared definitions for the instruction memory loader.
package ins_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int MEM_BYTES_DEF  = 400;

endpackage

// File: rtl/ins_loader.sv
// Instruction memory loader: accepts 32-bit words from a host and writes them
// big-endian, one byte per cycle, at consecutive addresses from 0.
//
// state   | meaning
// S_IDLE  | out of reset, waiting for start
// S_LOAD  | word_ready high, waiting for a host word
// S_WRITE | serializing the latched word, one byte per cycle
// S_DONE  | session finished (err flags overflow), waiting for start
module ins_loader
  import ins_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word,
  input  logic        word_last,
  output logic        word_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] word_cnt
);

  state_t      state;
  logic [31:0] ptr;
  logic [23:0] shreg;
  logic [1:0]  idx;
  logic        last_q;
  logic        fits;

  // Widen to 33 bits so ptr+4 cannot wrap past the memory size check.
  assign fits = ({1'b0, ptr} + 33'(BYTES_PER_WORD)) <= 33'(MEM_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      shreg      <= '0;
      idx        <= '0;
      last_q     <= 1'b0;
      word_ready <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            ptr        <= '0;
            word_cnt   <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            word_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (word_valid && word_ready) begin
            word_ready <= 1'b0;
            if (fits) begin
              state  <= S_WRITE;
              last_q <= word_last;
              we     <= 1'b1;
              waddr  <= ptr;
              wdata  <= word[31:24];
              shreg  <= word[23:0];
              idx    <= 2'd0;
            end else begin
              state <= S_DONE;
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          // idx is the byte currently presented on waddr/wdata.
          if (idx == 2'd3) begin
            we       <= 1'b0;
            ptr      <= ptr + 32'(BYTES_PER_WORD);
            word_cnt <= word_cnt + 32'd1;
            if (last_q) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state      <= S_LOAD;
              word_ready <= 1'b1;
            end
          end else begin
            idx   <= idx + 2'd1;
            waddr <= ptr + {30'd0, idx} + 32'd1;
            wdata <= shreg[23:16];
            shreg <= {shreg[15:0], 8'h00};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
